motion_subtract: RTL and testbench

Background-subtraction stage of the motion-detect pipeline. Sits between the two grayscale converters (background and frame) and the highlight stage. Pops one 8-bit gray pixel from each input FIFO and computes their absolute difference. Pushes an 8-bit mask pixel (0xFF = motion, 0x00 = static) into the mask FIFO consumed by the highlight stage, at up to one pixel per cycle.

---
 rtl/motion_pkg.sv | 29 ++
 rtl/motion_subtract.sv | 90 +++++++++
 tb/tb_motion_subtract.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/motion_pkg.sv
// Shared types, constants and helpers for the motion-detect pipeline.
package motion_pkg;

  localparam int unsigned PIXEL_W = 8;
  localparam int unsigned RGB_W   = 24;

  localparam logic [PIXEL_W-1:0] MASK_ON  = 8'hFF;
  localparam logic [PIXEL_W-1:0] MASK_OFF = 8'h00;

  // Default frame geometry and motion threshold
  localparam int unsigned DEF_WIDTH     = 768;
  localparam int unsigned DEF_HEIGHT    = 576;
  localparam int unsigned DEF_THRESHOLD = 50;

  // Output register occupancy
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } fill_state_e;

  // |a - b| via a 9-bit signed subtract; the result always fits in 8 bits
  function automatic logic [PIXEL_W-1:0] abs_diff8(input logic [PIXEL_W-1:0] a,
                                                   input logic [PIXEL_W-1:0] b);
    logic [PIXEL_W:0] d;
    d = {1'b0, a} - {1'b0, b};
    return d[PIXEL_W] ? PIXEL_W'(-d) : PIXEL_W'(d);
  endfunction

endpackage

// File: rtl/motion_subtract.sv
// Background subtraction: pops one gray pixel from the background and frame
// FIFOs together, thresholds |frame - bg| into a 0xFF/0x00 mask pixel and
// pushes it to the mask FIFO at up to one pixel per cycle.
//
// Ports:
//   clock, reset              rising-edge clock, synchronous active-high reset
//   bg_empty/bg_dout          background FIFO (FWFT), popped with bg_rd_en
//   frame_empty/frame_dout    frame FIFO (FWFT), popped with frame_rd_en
//   mask_full                 mask FIFO full
//   mask_wr_en/mask_din       mask FIFO push and data
//   frame_done                pulses on the push of the last pixel of a frame
module motion_subtract
  import motion_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned HEIGHT    = DEF_HEIGHT,
  parameter int unsigned THRESHOLD = DEF_THRESHOLD
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               bg_empty,
  input  logic [PIXEL_W-1:0] bg_dout,
  output logic               bg_rd_en,
  input  logic               frame_empty,
  input  logic [PIXEL_W-1:0] frame_dout,
  output logic               frame_rd_en,
  input  logic               mask_full,
  output logic               mask_wr_en,
  output logic [PIXEL_W-1:0] mask_din,
  output logic               frame_done
);

  localparam int unsigned NPIX  = WIDTH * HEIGHT;
  localparam int unsigned CNT_W = (NPIX > 1) ? $clog2(NPIX) : 1;

  fill_state_e        state_q, state_d;
  logic [PIXEL_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               out_valid;
  logic               take;
  logic               push;
  logic               last;
  logic [PIXEL_W-1:0] diff;

  assign out_valid = (state_q == ST_FULL);

  // Output register, pixel counter and occupancy state
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  // Handshake, threshold and next-state logic. Pops and pushes are masked
  // during reset so a pending pixel is dropped and the FIFOs are untouched.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    push    = out_valid && !mask_full && !reset;
    take    = !bg_empty && !frame_empty && (!out_valid || !mask_full) && !reset;
    last    = (cnt_q == CNT_W'(NPIX - 1));
    diff    = abs_diff8(frame_dout, bg_dout);

    if (push) begin
      cnt_d = last ? '0 : cnt_q + CNT_W'(1);
    end

    if (take) begin
      data_d  = (32'(diff) > THRESHOLD) ? MASK_ON : MASK_OFF;
      state_d = ST_FULL;
    end else if (push) begin
      state_d = ST_EMPTY;
    end
  end

  assign bg_rd_en    = take;
  assign frame_rd_en = take;
  assign mask_wr_en  = push;
  assign mask_din    = data_q;
  assign frame_done  = push && last;

endmodule

// File: tb/tb_motion_subtract.sv
// Directed bench for motion_subtract on a 4x2 frame with threshold 50.
module tb_motion_subtract;

  logic       clock = 1'b0;
  logic       reset;
  logic       bg_empty, frame_empty, mask_full;
  logic [7:0] bg_dout, frame_dout;
  logic       bg_rd_en, frame_rd_en, mask_wr_en, frame_done;
  logic [7:0] mask_din;

  always #5 clock = ~clock;

  motion_subtract #(.WIDTH(4), .HEIGHT(2), .THRESHOLD(50)) dut (
    .clock(clock), .reset(reset),
    .bg_empty(bg_empty), .bg_dout(bg_dout), .bg_rd_en(bg_rd_en),
    .frame_empty(frame_empty), .frame_dout(frame_dout), .frame_rd_en(frame_rd_en),
    .mask_full(mask_full), .mask_wr_en(mask_wr_en), .mask_din(mask_din),
    .frame_done(frame_done)
  );

  typedef struct {
    logic [7:0] bg;
    logic [7:0] fr;
    logic [7:0] m;
  } px_t;

  px_t q[$];
  int  total = 0;
  int  bad   = 0;

  // Reference of the output register and pixel counter
  bit         m_valid = 1'b0;
  logic [7:0] m_data  = 8'h00;
  int         m_cnt   = 0;

  bit bg_block = 1'b0;
  bit fr_block = 1'b0;
  int npush    = 0;
  int nfd      = 0;
  int fd_at[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic add(input int b, input int f, input int m);
    px_t p;
    p.bg = 8'(b);
    p.fr = 8'(f);
    p.m  = 8'(m);
    q.push_back(p);
  endtask

  task automatic drive_inputs();
    bg_empty    = (q.size() == 0) || bg_block;
    frame_empty = (q.size() == 0) || fr_block;
    bg_dout     = (q.size() != 0) ? q[0].bg : 8'h00;
    frame_dout  = (q.size() != 0) ? q[0].fr : 8'h00;
  endtask

  // One clock: drive, check every handshake output, advance the reference
  task automatic tick();
    bit exp_push, exp_take, exp_fd;
    drive_inputs();
    #1;
    exp_push = m_valid && !mask_full && !reset;
    exp_take = (q.size() != 0) && !bg_block && !fr_block &&
               (!m_valid || !mask_full) && !reset;
    exp_fd   = exp_push && (m_cnt == 7);
    chk("bg_rd_en", 32'(bg_rd_en), 32'(exp_take));
    chk("frame_rd_en", 32'(frame_rd_en), 32'(exp_take));
    chk("mask_wr_en", 32'(mask_wr_en), 32'(exp_push));
    chk("frame_done", 32'(frame_done), 32'(exp_fd));
    if (m_valid) chk("mask_din", 32'(mask_din), 32'(m_data));
    if (reset) begin
      m_valid = 1'b0;
      m_data  = 8'h00;
      m_cnt   = 0;
    end else begin
      if (exp_push) begin
        npush++;
        if (exp_fd) begin
          nfd++;
          fd_at.push_back(npush);
        end
        m_cnt = (m_cnt == 7) ? 0 : m_cnt + 1;
      end
      if (exp_take) begin
        m_data  = q[0].m;
        m_valid = 1'b1;
        void'(q.pop_front());
      end else if (exp_push) begin
        m_valid = 1'b0;
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic drain(output int n);
    n = 0;
    while ((q.size() != 0 || m_valid) && n < 200) begin
      tick();
      n++;
    end
    chk("drain_bound", 32'(q.size() != 0 || m_valid), 32'd0);
  endtask

  task automatic clear_stats();
    npush = 0;
    nfd   = 0;
    fd_at.delete();
  endtask

  initial begin
    int n;
    reset     = 1'b1;
    mask_full = 1'b0;
    drive_inputs();
    @(posedge clock);
    #1;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    drive_inputs();
    #1;
    chk("rst_mask_din", 32'(mask_din), 32'h00);
    chk("rst_mask_wr_en", 32'(mask_wr_en), 32'd0);
    chk("rst_rd_en", 32'(bg_rd_en), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    tick();

    // Single pixels across the threshold, pushed one cycle after the pop
    add(100, 151, 8'hFF);
    tick();
    chk("lat_push", 32'(mask_wr_en), 32'd1);
    chk("lat_data", 32'(mask_din), 32'hFF);
    tick();
    add(100, 150, 8'h00);
    tick();
    tick();

    // Wrap/underflow of the subtract
    add(200, 10, 8'hFF);
    add(10, 10, 8'h00);
    add(255, 0, 8'hFF);
    drain(n);

    // Backpressure: mask FIFO full for 5 cycles mid-stream
    clear_stats();
    add(0, 51, 8'hFF);  add(0, 50, 8'h00); add(0, 0, 8'h00);  add(0, 255, 8'hFF);
    add(0, 100, 8'hFF); add(0, 49, 8'h00); add(0, 60, 8'hFF); add(0, 20, 8'h00);
    tick(); tick(); tick();
    mask_full = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    mask_full = 1'b0;
    drain(n);
    chk("bp_pushes", 32'(npush), 32'd8);

    // Unequal arrival: frame data waits for background data
    bg_block = 1'b1;
    add(10, 70, 8'hFF); add(10, 60, 8'h00); add(90, 30, 8'hFF);
    tick(); tick(); tick();
    chk("uneq_waiting", 32'(q.size()), 32'd3);
    bg_block = 1'b0;
    drain(n);

    // Full frames back-to-back at one pixel per cycle
    reset = 1'b1;
    tick();
    reset = 1'b0;
    clear_stats();
    add(0, 51, 8'hFF);    add(0, 50, 8'h00);    add(51, 0, 8'hFF);    add(50, 0, 8'h00);
    add(128, 128, 8'h00); add(128, 179, 8'hFF); add(179, 128, 8'hFF); add(128, 178, 8'h00);
    add(255, 204, 8'hFF); add(255, 205, 8'h00); add(1, 254, 8'hFF);   add(254, 1, 8'hFF);
    add(30, 80, 8'h00);   add(30, 81, 8'hFF);   add(77, 77, 8'h00);   add(0, 255, 8'hFF);
    drain(n);
    chk("ff_cycles", 32'(n), 32'd17);
    chk("ff_pushes", 32'(npush), 32'd16);
    chk("ff_done_count", 32'(nfd), 32'd2);
    if (fd_at.size() == 2) begin
      chk("ff_done_first", 32'(fd_at[0]), 32'd8);
      chk("ff_done_second", 32'(fd_at[1]), 32'd16);
    end

    // Reset mid-frame after 3 pushes with a pixel pending
    clear_stats();
    add(0, 100, 8'hFF); add(100, 0, 8'hFF); add(5, 5, 8'h00);
    add(9, 70, 8'hFF);  add(70, 20, 8'h00); add(20, 200, 8'hFF);
    for (int i = 0; i < 4; i++) tick();
    chk("mid_pushes", 32'(npush), 32'd3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive_inputs();
    #1;
    chk("mid_rst_wr_en", 32'(mask_wr_en), 32'd0);
    chk("mid_rst_din", 32'(mask_din), 32'h00);
    chk("mid_rst_done", 32'(frame_done), 32'd0);
    chk("mid_rst_left", 32'(q.size()), 32'd2);
    clear_stats();
    add(1, 2, 8'h00);   add(3, 200, 8'hFF); add(200, 3, 8'hFF);
    add(60, 10, 8'h00); add(61, 10, 8'hFF); add(0, 0, 8'h00);
    drain(n);
    chk("mid_pushes_after", 32'(npush), 32'd8);
    chk("mid_done_count", 32'(nfd), 32'd1);
    if (fd_at.size() == 1) chk("mid_done_at", 32'(fd_at[0]), 32'd8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
